prog_scheduler: RTL and testbench

PROG_SCHEDULER -- requirements
Module: prog_scheduler

---
 rtl/prog_scheduler_if.sv | 26 ++
 rtl/prog_scheduler.sv | 117 +++++++++++
 tb/tb_prog_scheduler.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/prog_scheduler_if.sv
// rtl/prog_scheduler_if.sv - Request, loader and completion signals of the program scheduler
interface prog_scheduler_if;
  logic [1:0]  req;
  logic [1:0]  slot0;
  logic [1:0]  slot1;
  logic        load_fin;
  logic        done_in;
  logic [1:0]  gnt;
  logic        drive;
  logic [1:0]  slot_out;
  logic        busy;
  logic        resp_valid;
  logic        resp_id;
  logic [1:0]  resp_status;
  logic [15:0] run_cycles;

  modport master (
    output req, slot0, slot1, load_fin, done_in,
    input  gnt, drive, slot_out, busy, resp_valid, resp_id, resp_status, run_cycles
  );

  modport slave (
    input  req, slot0, slot1, load_fin, done_in,
    output gnt, drive, slot_out, busy, resp_valid, resp_id, resp_status, run_cycles
  );
endinterface

// File: rtl/prog_scheduler.sv
// rtl/prog_scheduler.sv - Round-robin program-load/run scheduler for two requesters
module prog_scheduler #(
  parameter int LOAD_TIMEOUT = 4096,
  parameter int RUN_LIMIT    = 1024
) (
  input logic             clk,
  input logic             rst,
  prog_scheduler_if.slave bus
);
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RELEASE, S_RUN, S_REPORT} state_e;

  localparam logic [15:0] LOAD_LAST = 16'(LOAD_TIMEOUT - 1);
  localparam logic [15:0] RUN_LAST  = 16'(RUN_LIMIT - 1);

  state_e      state_q;
  logic [1:0]  gnt_q;
  logic [1:0]  slot_q;
  logic        drive_q;
  logic        busy_q;
  logic        valid_q;
  logic        id_q;
  logic        last_q;
  logic        resp_id_q;
  logic [1:0]  status_q;
  logic [15:0] cnt_q;
  logic [15:0] run_cycles_q;

  logic        win_d;
  logic [1:0]  win_slot_d;
  logic [15:0] cnt_inc_d;

  // On a tie the requester not served last wins; otherwise the lone requester wins.
  always_comb begin
    win_d = bus.req[1];
    if (bus.req == 2'b11) win_d = ~last_q;
    win_slot_d = win_d ? bus.slot1 : bus.slot0;
    cnt_inc_d  = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      gnt_q        <= 2'b00;
      slot_q       <= 2'b00;
      drive_q      <= 1'b0;
      busy_q       <= 1'b0;
      valid_q      <= 1'b0;
      id_q         <= 1'b0;
      last_q       <= 1'b1;
      resp_id_q    <= 1'b0;
      status_q     <= 2'b00;
      cnt_q        <= 16'd0;
      run_cycles_q <= 16'd0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.req != 2'b00) begin
            state_q <= S_LOAD;
            gnt_q   <= win_d ? 2'b10 : 2'b01;
            id_q    <= win_d;
            slot_q  <= win_slot_d;
            drive_q <= 1'b1;
            busy_q  <= 1'b1;
            cnt_q   <= 16'd0;
          end
        end
        S_LOAD: begin
          cnt_q <= cnt_inc_d;
          if (bus.load_fin) begin
            state_q <= S_RELEASE;
            drive_q <= 1'b0;
          end else if (cnt_q >= LOAD_LAST) begin
            state_q      <= S_REPORT;
            drive_q      <= 1'b0;
            valid_q      <= 1'b1;
            resp_id_q    <= id_q;
            status_q     <= 2'b10;
            run_cycles_q <= 16'd0;
          end
        end
        S_RELEASE: begin
          if (!bus.load_fin) begin
            state_q <= S_RUN;
            cnt_q   <= 16'd0;
          end
        end
        S_RUN: begin
          cnt_q <= cnt_inc_d;
          if (bus.done_in || cnt_q >= RUN_LAST) begin
            state_q      <= S_REPORT;
            valid_q      <= 1'b1;
            resp_id_q    <= id_q;
            status_q     <= bus.done_in ? 2'b00 : 2'b01;
            run_cycles_q <= cnt_q;
          end
        end
        S_REPORT: begin
          state_q <= S_IDLE;
          gnt_q   <= 2'b00;
          busy_q  <= 1'b0;
          last_q  <= id_q;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.gnt         = gnt_q;
  assign bus.drive       = drive_q;
  assign bus.slot_out    = slot_q;
  assign bus.busy        = busy_q;
  assign bus.resp_valid  = valid_q;
  assign bus.resp_id     = resp_id_q;
  assign bus.resp_status = status_q;
  assign bus.run_cycles  = run_cycles_q;
endmodule

// File: tb/tb_prog_scheduler.sv
// tb/tb_prog_scheduler.sv - Directed self-checking bench for prog_scheduler
module tb_prog_scheduler;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] req = 2'b00;
  logic [1:0] slot0 = 2'b00;
  logic [1:0] slot1 = 2'b00;
  logic load_fin = 1'b0;
  logic done_in = 1'b0;
  logic sel = 1'b0;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  // Instance a uses default limits, instance b the short ones; both see the same stimulus.
  prog_scheduler_if if_a ();
  prog_scheduler_if if_b ();

  prog_scheduler u_dut_a (.clk(clk), .rst(rst), .bus(if_a.slave));
  prog_scheduler #(.LOAD_TIMEOUT(8), .RUN_LIMIT(16)) u_dut_b (.clk(clk), .rst(rst), .bus(if_b.slave));

  assign if_a.req = req;
  assign if_a.slot0 = slot0;
  assign if_a.slot1 = slot1;
  assign if_a.load_fin = load_fin;
  assign if_a.done_in = done_in;
  assign if_b.req = req;
  assign if_b.slot0 = slot0;
  assign if_b.slot1 = slot1;
  assign if_b.load_fin = load_fin;
  assign if_b.done_in = done_in;

  logic [1:0]  o_gnt, o_slot, o_status;
  logic        o_drive, o_busy, o_valid, o_id;
  logic [15:0] o_cycles;

  assign o_gnt    = sel ? if_b.gnt : if_a.gnt;
  assign o_slot   = sel ? if_b.slot_out : if_a.slot_out;
  assign o_status = sel ? if_b.resp_status : if_a.resp_status;
  assign o_drive  = sel ? if_b.drive : if_a.drive;
  assign o_busy   = sel ? if_b.busy : if_a.busy;
  assign o_valid  = sel ? if_b.resp_valid : if_a.resp_valid;
  assign o_id     = sel ? if_b.resp_id : if_a.resp_id;
  assign o_cycles = sel ? if_b.run_cycles : if_a.run_cycles;

  task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(2);
    rst = 1'b0;
  endtask

  task automatic check_resp(input string tag, input logic valid, input logic id,
                            input logic [1:0] status, input logic [15:0] cycles);
    expect_eq({tag, "_valid"}, 32'(o_valid), 32'(valid));
    expect_eq({tag, "_id"}, 32'(o_id), 32'(id));
    expect_eq({tag, "_status"}, 32'(o_status), 32'(status));
    expect_eq({tag, "_cycles"}, 32'(o_cycles), 32'(cycles));
  endtask

  // From the first LOAD cycle: quick load handshake, run_n RUN cycles, done, stop in REPORT.
  task automatic finish_txn(input int run_n);
    load_fin = 1'b1;
    step(1);
    load_fin = 1'b0;
    step(1);
    step(run_n);
    done_in = 1'b1;
    step(1);
    done_in = 1'b0;
  endtask

  initial begin
    // Reset state
    sel = 1'b0;
    do_reset();
    expect_eq("rst_gnt", 32'(o_gnt), 32'd0);
    expect_eq("rst_drive", 32'(o_drive), 32'd0);
    expect_eq("rst_slot", 32'(o_slot), 32'd0);
    expect_eq("rst_busy", 32'(o_busy), 32'd0);
    check_resp("rst", 1'b0, 1'b0, 2'b00, 16'd0);

    // Single request with slow loader
    req = 2'b01; slot0 = 2'd2;
    step(1);
    expect_eq("t1_gnt", 32'(o_gnt), 32'h1);
    expect_eq("t1_drive", 32'(o_drive), 32'd1);
    expect_eq("t1_slot", 32'(o_slot), 32'd2);
    expect_eq("t1_busy", 32'(o_busy), 32'd1);
    req = 2'b00;
    step(19);
    expect_eq("t1_drive_hold", 32'(o_drive), 32'd1);
    load_fin = 1'b1;
    step(1);
    expect_eq("t1_release_drive", 32'(o_drive), 32'd0);
    expect_eq("t1_release_gnt", 32'(o_gnt), 32'h1);
    step(2);
    load_fin = 1'b0;
    step(1);
    step(5);
    expect_eq("t1_run_novalid", 32'(o_valid), 32'd0);
    done_in = 1'b1;
    step(1);
    done_in = 1'b0;
    check_resp("t1_report", 1'b1, 1'b0, 2'b00, 16'd5);
    expect_eq("t1_report_gnt", 32'(o_gnt), 32'h1);
    step(1);
    expect_eq("t1_idle_gnt", 32'(o_gnt), 32'd0);
    expect_eq("t1_idle_busy", 32'(o_busy), 32'd0);
    check_resp("t1_hold", 1'b0, 1'b0, 2'b00, 16'd5);

    // Dropped request is never served
    req = 2'b01;
    #2 req = 2'b00;
    step(1);
    expect_eq("drop_gnt", 32'(o_gnt), 32'd0);

    // Round-robin tie
    do_reset();
    req = 2'b11; slot0 = 2'd1; slot1 = 2'd3;
    step(1);
    expect_eq("rr1_gnt", 32'(o_gnt), 32'h1);
    expect_eq("rr1_slot", 32'(o_slot), 32'd1);
    finish_txn(2);
    check_resp("rr1", 1'b1, 1'b0, 2'b00, 16'd2);
    expect_eq("rr1_report_gnt", 32'(o_gnt), 32'h1);
    step(1);
    expect_eq("rr1_idle_gnt", 32'(o_gnt), 32'd0);
    step(1);
    expect_eq("rr2_gnt", 32'(o_gnt), 32'h2);
    expect_eq("rr2_slot", 32'(o_slot), 32'd3);
    finish_txn(0);
    check_resp("rr2", 1'b1, 1'b1, 2'b00, 16'd0);
    step(1);
    expect_eq("rr2_idle_busy", 32'(o_busy), 32'd0);
    step(1);
    expect_eq("rr3_gnt", 32'(o_gnt), 32'h1);
    req = 2'b00;
    finish_txn(1);
    step(1);

    // Load timeout on the short-limit instance
    sel = 1'b1;
    do_reset();
    req = 2'b01; slot0 = 2'd1;
    step(1);
    req = 2'b00;
    expect_eq("lto_drive0", 32'(o_drive), 32'd1);
    step(7);
    expect_eq("lto_drive7", 32'(o_drive), 32'd1);
    expect_eq("lto_novalid", 32'(o_valid), 32'd0);
    step(1);
    expect_eq("lto_drive_fall", 32'(o_drive), 32'd0);
    check_resp("lto", 1'b1, 1'b0, 2'b10, 16'd0);
    step(1);
    expect_eq("lto_idle_busy", 32'(o_busy), 32'd0);

    // Run timeout
    do_reset();
    req = 2'b10; slot1 = 2'd3;
    step(1);
    expect_eq("rto_gnt", 32'(o_gnt), 32'h2);
    expect_eq("rto_slot", 32'(o_slot), 32'd3);
    req = 2'b00;
    load_fin = 1'b1;
    step(1);
    load_fin = 1'b0;
    step(1);
    step(15);
    expect_eq("rto_last_novalid", 32'(o_valid), 32'd0);
    expect_eq("rto_last_busy", 32'(o_busy), 32'd1);
    step(1);
    check_resp("rto", 1'b1, 1'b1, 2'b01, 16'd15);
    step(1);

    // done_in in the final RUN cycle wins over the limit
    req = 2'b01;
    step(1);
    req = 2'b00;
    finish_txn(15);
    check_resp("rdone", 1'b1, 1'b0, 2'b00, 16'd15);
    step(1);

    // Reset in the middle of RUN
    sel = 1'b0;
    do_reset();
    req = 2'b01; slot0 = 2'd0;
    step(1);
    req = 2'b00;
    load_fin = 1'b1;
    step(1);
    load_fin = 1'b0;
    step(4);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    expect_eq("mrst_gnt", 32'(o_gnt), 32'd0);
    expect_eq("mrst_drive", 32'(o_drive), 32'd0);
    expect_eq("mrst_busy", 32'(o_busy), 32'd0);
    expect_eq("mrst_valid", 32'(o_valid), 32'd0);
    step(1);
    expect_eq("mrst_valid2", 32'(o_valid), 32'd0);
    req = 2'b10; slot1 = 2'd1;
    step(1);
    expect_eq("mrst_new_gnt", 32'(o_gnt), 32'h2);
    expect_eq("mrst_new_slot", 32'(o_slot), 32'd1);
    req = 2'b00;
    finish_txn(4);
    check_resp("mrst_new", 1'b1, 1'b1, 2'b00, 16'd4);
    step(1);

    // Inputs changing while busy, done_in while idle
    do_reset();
    req = 2'b01; slot0 = 2'd2;
    step(1);
    slot0 = 2'd3; slot1 = 2'd1; req = 2'b10;
    step(2);
    expect_eq("ign_slot", 32'(o_slot), 32'd2);
    expect_eq("ign_gnt", 32'(o_gnt), 32'h1);
    req = 2'b00;
    finish_txn(1);
    check_resp("ign", 1'b1, 1'b0, 2'b00, 16'd1);
    step(1);
    done_in = 1'b1;
    step(2);
    done_in = 1'b0;
    expect_eq("idle_done_busy", 32'(o_busy), 32'd0);
    expect_eq("idle_done_valid", 32'(o_valid), 32'd0);
    expect_eq("idle_done_gnt", 32'(o_gnt), 32'd0);
    step(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
